multi_zone_light_ctrl: RTL and testbench
========================================

# multi_zone_light_ctrl

Parametrised successor to the single-zone lighting controller. It drives `NUM_ZONES` independent lighting zones, each with its own push button, infrared presence sensor, LED output and mode flag. Each zone adds two things the single-zone controller lacks: a blinking pre-shutdown warning, and a manual force-off that is inhibited until the sensor clears. The block sits directly under the board top level, with inputs taken straight from pins.

## Interface

- `NUM_ZONES`, 2: number of independent zones (1..8).
- `DEBOUNCE_P`, 300: consecutive stable cycles required to accept a button level change.
- `SWITCH_MODE_MIN_T`, 5000: debounced hold cycles that constitute a long press (mode toggle).
- `AUTO_SHUTDOWN_T`, 30000: auto-mode on-time in cycles after the last infrared detection.
- `WARN_T`, 5000: final cycles of the auto timer during which the LED blinks. Must be < `AUTO_SHUTDOWN_T`.
- `BLINK_HALF`, 250: half-period of the warning blink in cycles.

Ports:

- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `push_button` in `NUM_ZONES`: raw button per zone, active-high, asynchronous.
- `infravermelho` in `NUM_ZONES`: raw presence sensor per zone, active-high, asynchronous.
- `led` out `NUM_ZONES`: registered lamp drive per zone.
- `saida` out `NUM_ZONES`: registered mode flag per zone; 1 = automatic, 0 = manual.

## Operation

**Per-zone datapath (fully replicated, no sharing between zones)**
- **Input synchronisers:** 2-flop synchronisers on the button and on the sensor.
- **Debouncer:**
  - Counter of width `$clog2(DEBOUNCE_P+1)`; cleared on any cycle where the synchronised button equals `btn_stable`.
  - Increments while they differ.
  - When a mismatch is seen with counter == `DEBOUNCE_P-1`, `btn_stable` flips and the counter clears.
- **Hold counter:**
  - Clears on the cycle `btn_stable` rises.
  - Increments while `btn_stable`=1, saturating at `SWITCH_MODE_MIN_T`.
  - Reaching `SWITCH_MODE_MIN_T` produces a one-cycle `long_evt` and sets `long_done`.
- **Short press:** `short_evt` is a one-cycle pulse on a `btn_stable` falling edge when `long_done`=0. `long_done` clears on that falling edge.
- **Auto timer:** width `$clog2(AUTO_SHUTDOWN_T)`.

**FSM states:** MAN_OFF, MAN_ON, AUTO_IDLE, AUTO_ON.
- **MAN_OFF:** `short_evt` → MAN_ON; `long_evt` → AUTO_IDLE.
- **MAN_ON:** `short_evt` → MAN_OFF; `long_evt` → AUTO_IDLE.
- **AUTO_IDLE:**
  - `long_evt` → MAN_OFF.
  - Synchronised sensor = 1 and `armed`=1 → AUTO_ON, timer loaded with `AUTO_SHUTDOWN_T-1`.
- **AUTO_ON:**
  - `long_evt` → MAN_OFF.
  - `short_evt` → AUTO_IDLE with `armed` cleared (force-off).
  - Sensor = 1 → timer reloads to `AUTO_SHUTDOWN_T-1`.
  - Timer == 0 and sensor = 0 → AUTO_IDLE.
  - Otherwise the timer decrements.
- **`armed` flag:** sets on any cycle the synchronised sensor = 0; set at reset.
- **Priority within one cycle:** `long_evt` > `short_evt` > sensor > timer expiry.

**Outputs**
- `led` = 1 in MAN_ON.
- `led` = 1 in AUTO_ON while timer ≥ `WARN_T`.
- While timer < `WARN_T`, `led` follows the blink bit. The blink bit toggles every `BLINK_HALF` cycles, is reset to 1 on entry to the warning window, and is reset to 1 on every reload.
- `led` = 0 in MAN_OFF and AUTO_IDLE.
- `saida` = 1 in AUTO_IDLE/AUTO_ON, 0 otherwise.

**Reset (asynchronous):**
- State MAN_OFF; `led`=0, `saida`=0.
- `btn_stable`=0, all counters 0, synchronisers 0.
- `armed`=1, blink bit 1.

## Timing

- **Button to stable:** a button change first sampled at edge 0 reaches synchroniser stage 2 at edge 1, and flips `btn_stable` at edge `DEBOUNCE_P+1`, provided it is held.
- **Short press:** `led`/state update at edge `DEBOUNCE_P+2` after the release is first sampled.
- **Long press:** `long_evt` fires `SWITCH_MODE_MIN_T` cycles after `btn_stable` rises; `saida` and state update on the following edge. Releasing afterwards has no effect.
- **Glitches:** a glitch shorter than `DEBOUNCE_P` cycles produces no event.
- **Sensor to `led`:** 3 edges (2 synchroniser + 1 FSM).
- **Auto timeout:** with the sensor low after its last high sample, `led` falls `AUTO_SHUTDOWN_T` cycles after the last reload.
- **Reset mid-operation:** outputs clear immediately (asynchronously); the first event can occur no earlier than edge `DEBOUNCE_P+2` after `rst` deasserts.

## Test plan

Bench parameters: `NUM_ZONES`=2, `DEBOUNCE_P`=4, `SWITCH_MODE_MIN_T`=20, `AUTO_SHUTDOWN_T`=50, `WARN_T`=10, `BLINK_HALF`=2.

1. **Reset values:** assert `rst` mid-cycle with zone 0 in MAN_ON → `led`=00 and `saida`=00 immediately; after release, both stay 00 with no input.
2. **Short press and bounce:** zone 0 press held 10 cycles then released; also a 3-cycle glitch.
   - The press toggles `led[0]` to 1 exactly 6 edges after the release is sampled.
   - The glitch produces no change; zone 1 is untouched.
3. **Long press:** zone 1 held 30 cycles → `saida[1]`=1 on the edge after hold count 20; release produces no `led` toggle. A second 30-cycle hold returns `saida[1]`=0 with `led[1]`=0.
4. **Auto timeout with warning:** zone 0 in auto, sensor pulsed high 1 cycle.
   - `led[0]`=1 three edges later.
   - Steady 1 for 40 cycles, then blinks with pattern 1,1,0,0 for 10 cycles, then 0.
   - A sensor pulse during the blink reloads the timer and returns `led[0]` to steady 1.
5. **Force-off and re-arm:** zone 0 in AUTO_ON with the sensor held high; short press → AUTO_IDLE and `led[0]`=0. `led[0]` stays 0 while the sensor remains high, and re-lights only after the sensor drops low for ≥1 cycle and then rises.
6. **Simultaneous events:** `long_evt` coincides with a sensor high in AUTO_ON → state MAN_OFF, `saida`=0, `led`=0. Both zones are stimulated concurrently with independent outcomes.

Source files
------------

// File: rtl/multi_zone_light_ctrl.sv
// Multi-zone lighting controller.
// Each zone has its own synchronisers, button debouncer, short/long press
// classifier and a four-state mode FSM. In auto mode the lamp blinks during
// the final WARN_T cycles before switching off. A short press in auto mode
// forces the lamp off, and it stays off until the sensor has cleared once.
module multi_zone_light_ctrl #(
  parameter int NUM_ZONES         = 2,
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5000,
  parameter int AUTO_SHUTDOWN_T   = 30000,
  parameter int WARN_T            = 5000,
  parameter int BLINK_HALF        = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ZONES-1:0] push_button,
  input  logic [NUM_ZONES-1:0] infravermelho,
  output logic [NUM_ZONES-1:0] led,
  output logic [NUM_ZONES-1:0] saida
);

  localparam int DEB_W  = $clog2(DEBOUNCE_P + 1);
  localparam int HOLD_W = $clog2(SWITCH_MODE_MIN_T + 1);
  localparam int TMR_W  = (AUTO_SHUTDOWN_T > 1) ? $clog2(AUTO_SHUTDOWN_T) : 1;
  localparam int BLK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_P - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(SWITCH_MODE_MIN_T);
  localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(AUTO_SHUTDOWN_T - 1);
  localparam logic [TMR_W-1:0]  TMR_WARN   = TMR_W'(WARN_T);
  localparam logic [TMR_W-1:0]  TMR_ENTRY  = TMR_W'(WARN_T - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {MAN_OFF, MAN_ON, AUTO_IDLE, AUTO_ON} state_t;

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    logic              btn_p0, btn_p1, ir_p0, ir_p1;
    logic [DEB_W-1:0]  deb_cnt;
    logic              btn_stable, btn_flip;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done, long_evt, short_evt, force_off;
    state_t            state, state_n;
    logic [TMR_W-1:0]  tmr, tmr_n;
    logic [BLK_W-1:0]  bcnt, bcnt_n;
    logic              blink, blink_n, armed, led_r, saida_r;

    // Two-flop synchronisers for the raw button and sensor pins
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        btn_p0 <= 1'b0;
        btn_p1 <= 1'b0;
        ir_p0  <= 1'b0;
        ir_p1  <= 1'b0;
      end else begin
        btn_p0 <= push_button[z];
        btn_p1 <= btn_p0;
        ir_p0  <= infravermelho[z];
        ir_p1  <= ir_p0;
      end
    end

    assign btn_flip = (btn_p1 != btn_stable) && (deb_cnt == DEB_LAST);

    // Debouncer: accept a new level after DEBOUNCE_P consecutive mismatches
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb_cnt    <= '0;
        btn_stable <= 1'b0;
      end else if (btn_p1 == btn_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_stable <= btn_p1;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end

    assign long_evt = btn_stable && (hold_cnt == HOLD_MAX) && !long_done;

    // Press classifier: saturating hold counter, long and short events
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
        short_evt <= 1'b0;
      end else begin
        short_evt <= btn_flip && btn_stable && !long_done && !long_evt;
        if (btn_flip && !btn_stable)
          hold_cnt <= '0;
        else if (btn_stable && (hold_cnt != HOLD_MAX))
          hold_cnt <= hold_cnt + HOLD_W'(1);
        if (btn_flip && btn_stable)
          long_done <= 1'b0;
        else if (long_evt)
          long_done <= 1'b1;
      end
    end

    // A short press during AUTO_ON disarms the sensor until it reads low
    assign force_off = (state == AUTO_ON) && short_evt && !long_evt;

    // Next-state, auto timer and warning blink; priority long > short > sensor > expiry
    always_comb begin
      state_n = state;
      tmr_n   = tmr;
      blink_n = blink;
      bcnt_n  = bcnt;
      case (state)
        MAN_OFF: begin
          if (long_evt)       state_n = AUTO_IDLE;
          else if (short_evt) state_n = MAN_ON;
        end
        MAN_ON: begin
          if (long_evt)       state_n = AUTO_IDLE;
          else if (short_evt) state_n = MAN_OFF;
        end
        AUTO_IDLE: begin
          if (long_evt) begin
            state_n = MAN_OFF;
          end else if (ir_p1 && armed) begin
            state_n = AUTO_ON;
            tmr_n   = TMR_RELOAD;
            blink_n = 1'b1;
            bcnt_n  = '0;
          end
        end
        AUTO_ON: begin
          if (long_evt) begin
            state_n = MAN_OFF;
          end else if (short_evt) begin
            state_n = AUTO_IDLE;
          end else if (ir_p1) begin
            tmr_n   = TMR_RELOAD;
            blink_n = 1'b1;
            bcnt_n  = '0;
          end else if (tmr == '0) begin
            state_n = AUTO_IDLE;
          end else begin
            tmr_n = tmr - TMR_W'(1);
            if (tmr_n == TMR_ENTRY) begin
              blink_n = 1'b1;
              bcnt_n  = '0;
            end else if (tmr_n < TMR_WARN) begin
              if (bcnt == BLK_LAST) begin
                blink_n = ~blink;
                bcnt_n  = '0;
              end else begin
                bcnt_n = bcnt + BLK_W'(1);
              end
            end
          end
        end
        default: state_n = MAN_OFF;
      endcase
    end

    // Mode FSM registers with registered lamp and mode outputs
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= MAN_OFF;
        tmr     <= '0;
        blink   <= 1'b1;
        bcnt    <= '0;
        armed   <= 1'b1;
        led_r   <= 1'b0;
        saida_r <= 1'b0;
      end else begin
        state   <= state_n;
        tmr     <= tmr_n;
        blink   <= blink_n;
        bcnt    <= bcnt_n;
        armed   <= !ir_p1 || (armed && !force_off);
        led_r   <= (state_n == MAN_ON) ||
                   ((state_n == AUTO_ON) && ((tmr_n >= TMR_WARN) || blink_n));
        saida_r <= (state_n == AUTO_IDLE) || (state_n == AUTO_ON);
      end
    end

    assign led[z]   = led_r;
    assign saida[z] = saida_r;
  end

endmodule

// File: tb/tb_multi_zone_light_ctrl.sv
// Scoreboard bench for multi_zone_light_ctrl: stimulus queues expected
// (led, saida) values tagged with the edge number they must appear after;
// a negedge monitor pops and compares them.
module tb_multi_zone_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] push_button = 2'b00;
  logic [1:0] infravermelho = 2'b00;
  logic [1:0] led, saida;

  multi_zone_light_ctrl #(
    .NUM_ZONES(2), .DEBOUNCE_P(4), .SWITCH_MODE_MIN_T(20),
    .AUTO_SHUTDOWN_T(50), .WARN_T(10), .BLINK_HALF(2)
  ) dut (
    .clk(clk), .rst(rst), .push_button(push_button),
    .infravermelho(infravermelho), .led(led), .saida(saida)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] led;
    logic [1:0] saida;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // posedge counter: outputs seen at negedge N reflect edge N
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic expect_at(input int c, input logic [1:0] l, input logic [1:0] s, input string n);
    exp_t e;
    int   i;
    e.cyc = c; e.led = l; e.saida = s; e.name = n;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        total++;
        if (e.cyc != cyc) begin
          bad++;
          $display("FAIL %s: check for edge %0d missed (now %0d)", e.name, e.cyc, cyc);
        end else if (led !== e.led || saida !== e.saida) begin
          bad++;
          $display("FAIL %s @%0d: led=%b saida=%b, want led=%b saida=%b",
                   e.name, cyc, led, saida, e.led, e.saida);
        end
      end
    end
  end

  initial begin
    int k, m, g, c, L, L2, L3;
    exp_t e;

    // reset values
    step(2);
    expect_at(cyc, 2'b00, 2'b00, "reset_hold");
    rst = 1'b0;
    expect_at(cyc + 3, 2'b00, 2'b00, "post_reset_idle_a");
    expect_at(cyc + 12, 2'b00, 2'b00, "post_reset_idle_b");
    step(14);

    // short press zone 0 (10 cycles)
    k = cyc;
    push_button[0] = 1'b1;
    expect_at(k + 16, 2'b00, 2'b00, "short_before");
    expect_at(k + 17, 2'b01, 2'b00, "short_led_on");
    step(10);
    push_button[0] = 1'b0;
    step(20);

    // 3-cycle glitch on zone 0
    g = cyc;
    push_button[0] = 1'b1;
    expect_at(g + 8, 2'b01, 2'b00, "glitch_no_toggle_a");
    expect_at(g + 14, 2'b01, 2'b00, "glitch_no_toggle_b");
    step(3);
    push_button[0] = 1'b0;
    step(16);

    // asynchronous reset mid-cycle with zone 0 in MAN_ON
    c = cyc;
    expect_at(c, 2'b01, 2'b00, "pre_reset_on");
    step(1);
    #1;
    rst = 1'b1;
    expect_at(c + 1, 2'b00, 2'b00, "reset_async");
    step(2);
    rst = 1'b0;
    expect_at(cyc + 2, 2'b00, 2'b00, "reset_release_a");
    expect_at(cyc + 10, 2'b00, 2'b00, "reset_release_b");
    step(12);

    // concurrent long press, both zones to auto
    k = cyc;
    push_button = 2'b11;
    expect_at(k + 26, 2'b00, 2'b00, "long_before");
    expect_at(k + 27, 2'b00, 2'b11, "long_both_auto");
    expect_at(k + 38, 2'b00, 2'b11, "long_release_noop_a");
    expect_at(k + 45, 2'b00, 2'b11, "long_release_noop_b");
    step(30);
    push_button = 2'b00;
    step(45);

    // second long press zone 1 back to manual
    k = cyc;
    push_button[1] = 1'b1;
    expect_at(k + 26, 2'b00, 2'b11, "long2_before");
    expect_at(k + 27, 2'b00, 2'b01, "long2_manual");
    expect_at(k + 40, 2'b00, 2'b01, "long2_after");
    step(30);
    push_button[1] = 1'b0;
    step(20);

    // auto timeout with warning blink on zone 0
    k = cyc;
    L = k + 3;
    infravermelho[0] = 1'b1;
    expect_at(L - 1, 2'b00, 2'b01, "sensor_latency_before");
    expect_at(L, 2'b01, 2'b01, "sensor_latency");
    expect_at(L + 20, 2'b01, 2'b01, "auto_steady_mid");
    expect_at(L + 39, 2'b01, 2'b01, "auto_steady_last");
    for (int i = 0; i < 10; i++)
      expect_at(L + 40 + i, {1'b0, ((i % 4) < 2)}, 2'b01, "warn_blink");
    expect_at(L + 50, 2'b00, 2'b01, "auto_timeout");
    step(1);
    infravermelho[0] = 1'b0;
    step(55);

    // sensor pulse during blink reloads the timer
    k = cyc;
    L2 = k + 3;
    L3 = L2 + 46;
    infravermelho[0] = 1'b1;
    expect_at(L2 + 43, 2'b00, 2'b01, "warn_low_phase");
    expect_at(L2 + 45, 2'b01, 2'b01, "warn_high_phase");
    step(1);
    infravermelho[0] = 1'b0;
    step(45);
    infravermelho[0] = 1'b1;
    step(1);
    infravermelho[0] = 1'b0;
    step(1);
    infravermelho[0] = 1'b1;
    expect_at(L3, 2'b01, 2'b01, "reload_in_warn");
    expect_at(L3 + 10, 2'b01, 2'b01, "reload_steady");
    expect_at(L3 + 40, 2'b01, 2'b01, "sensor_held_on");
    step(42);

    // force-off with sensor held high, then re-arm
    k = cyc;
    push_button[0] = 1'b1;
    expect_at(k + 16, 2'b01, 2'b01, "forceoff_before");
    expect_at(k + 17, 2'b00, 2'b01, "forceoff");
    expect_at(k + 20, 2'b00, 2'b01, "forceoff_inhibit_a");
    expect_at(k + 35, 2'b00, 2'b01, "forceoff_inhibit_b");
    step(10);
    push_button[0] = 1'b0;
    step(30);
    m = cyc;
    infravermelho[0] = 1'b0;
    expect_at(m + 3, 2'b00, 2'b01, "rearm_wait");
    expect_at(m + 4, 2'b01, 2'b01, "rearm_relight");
    step(1);
    infravermelho[0] = 1'b1;
    step(10);

    // zone 0 long press over active sensor, zone 1 short press concurrently
    k = cyc;
    push_button = 2'b11;
    expect_at(k + 16, 2'b01, 2'b01, "concurrent_before");
    expect_at(k + 17, 2'b11, 2'b01, "concurrent_z1_on");
    expect_at(k + 26, 2'b11, 2'b01, "concurrent_pre_long");
    expect_at(k + 27, 2'b10, 2'b00, "long_over_sensor");
    expect_at(k + 40, 2'b10, 2'b00, "long_over_sensor_hold");
    step(10);
    push_button[1] = 1'b0;
    step(20);
    push_button[0] = 1'b0;
    step(15);

    for (int i = 0; i < 300 && q.size() > 0; i++) step(1);
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: check for edge %0d never reached", e.name, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
